fetch_unit: RTL

- Instruction-fetch sequencer that sits directly downstream of the pc block and consumes its `out` value.
- Reads instruction memory at the current PC over a req/ack handshake and presents the fetched word to decode through a valid/ready interface.
- Drives the pc block's `sel` (NEXT/KEEP/LOAD) and `instr` (load target) inputs, so it fully controls PC advance, stall and redirect.

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit.sv | 112 +++++++++++
 2 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch path.
//   - pc select codes driven into the pc block's `sel` input
//   - fetch sequencer state encoding
//   - default datapath widths
package fetch_unit_pkg;

    localparam int unsigned DEFAULT_WORD_SIZE = 32;
    localparam int unsigned DEFAULT_ADDR_SIZE = 14;
    localparam int unsigned PC_OPT_SIZE       = 2;

    // Select codes understood by the pc block; 3 is never driven.
    localparam logic [PC_OPT_SIZE-1:0] NEXT_INSTR = 2'd0;
    localparam logic [PC_OPT_SIZE-1:0] KEEP_INSTR = 2'd1;
    localparam logic [PC_OPT_SIZE-1:0] LOAD_INSTR = 2'd2;

    typedef enum logic [1:0] {
        StReq   = 2'd0,
        StOut   = 2'd1,
        StDrain = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer between the pc block and decode.
// Reads instruction memory at the current PC over a req/ack handshake, holds the
// fetched word for decode on a valid/ready interface, and steers the pc block
// (advance, hold, or load a redirect target).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   pc                current PC from the pc block
//   pc_sel, pc_target select code and load target for the pc block (combinational)
//   mem_req, mem_addr instruction-memory read request and word address
//   mem_ack, mem_data one-cycle acknowledge with the fetched word
//   instr_valid/ready decode handshake
//   instr_out, instr_pc  fetched instruction and its PC (registered)
//   redirect, redirect_target  flush and load a new PC
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int unsigned ADDR_SIZE = DEFAULT_ADDR_SIZE,
    parameter int unsigned OPT_SIZE  = PC_OPT_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] pc,
    output logic [OPT_SIZE-1:0]  pc_sel,
    output logic [WORD_SIZE-1:0] pc_target,
    output logic                 mem_req,
    output logic [ADDR_SIZE-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_data,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [WORD_SIZE-1:0] instr_out,
    output logic [WORD_SIZE-1:0] instr_pc,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_target
);

    fetch_state_e         state_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic                 instr_valid_q;
    logic [WORD_SIZE-1:0] instr_out_q;
    logic [WORD_SIZE-1:0] instr_pc_q;
    logic [ADDR_SIZE-1:0] pc_addr;

    // Memory is word addressed; upper PC bits wrap.
    assign pc_addr = pc[ADDR_SIZE-1:0];

    assign pc_target   = redirect_target;
    assign instr_valid = instr_valid_q;
    assign instr_out   = instr_out_q;
    assign instr_pc    = instr_pc_q;

    always_comb begin
        mem_req  = 1'b0;
        mem_addr = pc_addr;
        pc_sel   = OPT_SIZE'(KEEP_INSTR);
        if (!rst) begin
            unique case (state_q)
                StReq: begin
                    mem_req = 1'b1;
                    if (mem_ack) pc_sel = OPT_SIZE'(NEXT_INSTR);
                end
                StDrain: begin
                    // PC may already point at the redirect target; keep the
                    // outstanding request's address until it is acknowledged.
                    mem_req  = 1'b1;
                    mem_addr = addr_q;
                end
                default: ;
            endcase
            if (redirect) pc_sel = OPT_SIZE'(LOAD_INSTR);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StReq;
            addr_q        <= '0;
            instr_valid_q <= 1'b0;
            instr_out_q   <= '0;
            instr_pc_q    <= '0;
        end else begin
            unique case (state_q)
                StReq: begin
                    addr_q <= pc_addr;
                    if (redirect) begin
                        // An ack in the redirect cycle closes the request and the
                        // stale word is dropped; otherwise wait it out in drain.
                        state_q <= mem_ack ? StReq : StDrain;
                    end else if (mem_ack) begin
                        instr_out_q   <= mem_data;
                        instr_pc_q    <= pc;
                        instr_valid_q <= 1'b1;
                        state_q       <= StOut;
                    end
                end
                StOut: begin
                    if (redirect || instr_ready) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= StReq;
                    end
                end
                StDrain: begin
                    if (mem_ack) state_q <= StReq;
                end
                default: state_q <= StReq;
            endcase
        end
    end

endmodule
